// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_ctrl_pkg
//  Brief    : Shared state encoding, timer status codes and helpers for the
//             timer_ctrl block.
//  Revision : 1.0 - initial release
// ============================================================================
package timer_ctrl_pkg;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PWR      = 3'd1,
    S_WAIT_SET = 3'd2,
    S_LOAD     = 3'd3,
    S_SKIP     = 3'd4,
    S_RUN      = 3'd5,
    S_STOP     = 3'd6
  } state_e;

  // Timer status bus codes
  localparam logic [7:0] TMR_OFF = 8'hFF;
  localparam logic [7:0] TMR_SET = 8'h00;

  // Default watchdog limit for the WAIT_SET state
  localparam int WDOG_CYCLES_DEFAULT = 8;

  // Increment that sticks at all-ones
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_ctrl_expcnt.sv
`default_nettype none
// ============================================================================
//  Module   : timer_ctrl_expcnt
//  Brief    : Saturating 8-bit expiry counter with synchronous clear.
//             inc_val exposes the value the counter would take on an
//             increment so the controller can compare against a limit in
//             the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_ctrl_expcnt
  import timer_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count,
  output logic [7:0] inc_val
);

  logic [7:0] count_q;

  assign inc_val = sat_inc(count_q);
  assign count   = count_q;

  // Count register: clear wins over increment
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (inc) begin
      count_q <= inc_val;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : timer_ctrl
//  Brief    : Session controller for an external timer: powers it up, waits
//             for the setting phase, loads mode/value, then counts expiries
//             in one-shot or periodic mode.
//             Optional feature macro: TIMER_CTRL_WDOG_EN enables a watchdog
//             on the WAIT_SET state (err pulse + off after WDOG_CYCLES).
//  Revision : 1.0 - initial release
// ============================================================================
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_value,
  input  logic       cfg_mode,
  input  logic [7:0] cfg_periods,
  input  logic [7:0] tmr_out,
  output logic       on,
  output logic       off,
  output logic       ok,
  output logic       mode,
  output logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] expiries
);

  state_e     state_q, state_d;
  logic [7:0] cfg_value_q;
  logic       cfg_mode_q;
  logic [7:0] cfg_periods_q;
  logic       cap;
  logic       exp_clr;
  logic       exp_inc;
  logic [7:0] exp_next;

`ifdef TIMER_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_d;
`else
  // Parameter kept so both builds share one instantiation interface
  logic [31:0] unused_wdog_cycles;
  assign unused_wdog_cycles = WDOG_CYCLES;
  assign err = 1'b0;
`endif

  timer_ctrl_expcnt u_expcnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (exp_clr),
    .inc     (exp_inc),
    .count   (expiries),
    .inc_val (exp_next)
  );

  assign busy  = (state_q != S_IDLE);
  assign mode  = cfg_mode_q;
  assign value = cfg_value_q;

  // Next-state and command decode; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    on      = 1'b0;
    off     = 1'b0;
    ok      = 1'b0;
    done    = 1'b0;
    cap     = 1'b0;
    exp_clr = 1'b0;
    exp_inc = 1'b0;
`ifdef TIMER_CTRL_WDOG_EN
    err_d   = 1'b0;
`endif
    if ((state_q != S_IDLE) && abort) begin
      off     = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cap     = 1'b1;
            exp_clr = 1'b1;
            state_d = S_PWR;
          end
        end
        S_PWR: begin
          on      = 1'b1;
          state_d = S_WAIT_SET;
        end
        S_WAIT_SET: begin
          if (tmr_out == TMR_SET) begin
            state_d = S_LOAD;
          end
`ifdef TIMER_CTRL_WDOG_EN
          else if (wdog_q == WDOG_W'(WDOG_CYCLES)) begin
            off     = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
        S_LOAD: begin
          ok      = 1'b1;
          state_d = S_SKIP;
        end
        S_SKIP: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          if (tmr_out == TMR_SET) begin
            exp_inc = 1'b1;
            if (!cfg_mode_q) begin
              // One-shot: the timer stops itself, so no off command
              done    = 1'b1;
              state_d = S_IDLE;
            end else if ((cfg_periods_q != 8'd0) && (exp_next == cfg_periods_q)) begin
              state_d = S_STOP;
            end
          end
        end
        S_STOP: begin
          off     = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

`ifdef TIMER_CTRL_WDOG_EN
  assign err = err_d;

  // Watchdog counts only consecutive cycles spent in WAIT_SET
  always_comb begin
    wdog_d = '0;
    if ((state_q == S_WAIT_SET) && (state_d == S_WAIT_SET)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  // State register and session config captured on start-accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cfg_value_q   <= 8'd0;
      cfg_mode_q    <= 1'b0;
      cfg_periods_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        cfg_value_q   <= cfg_value;
        cfg_mode_q    <= cfg_mode;
        cfg_periods_q <= cfg_periods;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_ctrl
//  Brief    : Directed self-checking bench for timer_ctrl with a cycle model
//             of the external timer. Cycle 0 of a session is the PWR cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, abort, cfg_mode;
  logic [7:0] cfg_value, cfg_periods;
  logic [7:0] tmr_out;
  logic       on, off, ok, mode, busy, done, err;
  logic [7:0] value, expiries;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.WDOG_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_value(cfg_value), .cfg_mode(cfg_mode), .cfg_periods(cfg_periods),
    .tmr_out(tmr_out), .on(on), .off(off), .ok(ok), .mode(mode),
    .value(value), .busy(busy), .done(done), .err(err), .expiries(expiries)
  );

  // Timer model: power-up 3 cycles, setting until ok, second setting cycle,
  // then count down; periodic reloads after 0, one-shot switches off.
  typedef enum {T_OFF, T_PWR, T_SET, T_SET2, T_RUN} tst_e;
  tst_e       ts = T_OFF;
  int         tm_pwr = 0;
  logic [7:0] tm_cnt = 8'd0, tm_val = 8'd0;
  logic       tm_mode = 1'b0;
  logic       stuck = 1'b0;

  always @(posedge clk) begin
    if (reset || off) begin
      ts <= T_OFF;
    end else begin
      case (ts)
        T_OFF:  if (on) begin ts <= T_PWR; tm_pwr <= 2; end
        T_PWR:  if (tm_pwr == 0) ts <= T_SET; else tm_pwr <= tm_pwr - 1;
        T_SET:  if (ok) begin ts <= T_SET2; tm_val <= value; tm_mode <= mode; end
        T_SET2: begin ts <= T_RUN; tm_cnt <= tm_val; end
        T_RUN: begin
          if (tm_cnt == 8'd0) begin
            if (tm_mode) tm_cnt <= tm_val;
            else ts <= T_OFF;
          end else begin
            tm_cnt <= tm_cnt - 8'd1;
          end
        end
        default: ts <= T_OFF;
      endcase
    end
  end

  assign tmr_out = stuck ? TMR_OFF :
                   ((ts == T_OFF) || (ts == T_PWR)) ? TMR_OFF :
                   ((ts == T_SET) || (ts == T_SET2)) ? TMR_SET : tm_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start; returns sampling the PWR cycle, with config inputs scrambled
  task automatic start_session(input logic [7:0] v, input logic m, input logic [7:0] p);
    cfg_value = v; cfg_mode = m; cfg_periods = p; start = 1'b1;
    tick();
    start = 1'b0; cfg_value = 8'hAA; cfg_mode = ~m; cfg_periods = 8'h55;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_tests++; if ({on, off, ok, done, err} !== 5'b0) begin n_fail++; $display("FAIL reset_cmds: got %b expected 00000", {on, off, ok, done, err}); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if ({mode, value, expiries} !== 17'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {mode, value, expiries}); end
    reset = 1'b0;
    tick();
  endtask

  // One-shot value=3: first zero at 4, ok at 5, done at 10
  task automatic run_oneshot(input string tag);
    int first_zero = -1, ok_cyc = -1, done_cyc = -1, bad_cmd = 0;
    n_tests++; if (on !== 1'b1) begin n_fail++; $display("FAIL %s_on: got %b expected 1", tag, on); end
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      start = (c == 2);
      cfg_value = (c == 2) ? 8'h09 : 8'hAA;
      tick();
      if (on === 1'b1 || (on + off + ok) > 1) bad_cmd++;
      if (first_zero < 0 && tmr_out === 8'h00) first_zero = c;
      if (ok === 1'b1 && ok_cyc < 0) begin
        ok_cyc = c;
        n_tests++; if ({mode, value} !== {1'b0, 8'd3}) begin n_fail++; $display("FAIL %s_load: got %b/%0d expected 0/3", tag, mode, value); end
      end
      if (done === 1'b1) begin
        done_cyc = c;
        n_tests++; if (off !== 1'b0) begin n_fail++; $display("FAIL %s_no_off: got %b expected 0", tag, off); end
      end
    end
    start = 1'b0;
    n_tests++; if (ok_cyc != first_zero + 1 || ok_cyc != 5) begin n_fail++; $display("FAIL %s_ok_cycle: got %0d expected 5 (first zero %0d)", tag, ok_cyc, first_zero); end
    n_tests++; if (done_cyc != 10) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected 10", tag, done_cyc); end
    n_tests++; if (bad_cmd != 0) begin n_fail++; $display("FAIL %s_cmds: got %0d bad cycles expected 0", tag, bad_cmd); end
    tick();
    n_tests++; if ({busy, expiries} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL %s_end: got busy=%b exp=%0d expected busy=0 exp=1", tag, busy, expiries); end
    tick(); tick();
    n_tests++; if (expiries !== 8'd1) begin n_fail++; $display("FAIL %s_hold: got %0d expected 1", tag, expiries); end
  endtask

  task automatic test_oneshot();
    start_session(8'd3, 1'b0, 8'd0);
    run_oneshot("oneshot");
  endtask

  // Periodic value=2 periods=3: expiries change at 10,13,16; STOP at 16
  task automatic test_periodic();
    int exp_cyc[3] = '{-1, -1, -1};
    int k = 0, done_cyc = -1;
    logic off_at_done = 1'b0;
    logic [7:0] prev;
    start_session(8'd2, 1'b1, 8'd3);
    prev = expiries;
    for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
      tick();
      if (expiries !== prev) begin
        if (k < 3) exp_cyc[k] = c;
        k++;
        prev = expiries;
      end
      if (done === 1'b1) begin done_cyc = c; off_at_done = off; end
    end
    n_tests++; if (exp_cyc[0] != 10 || exp_cyc[1] != 13 || exp_cyc[2] != 16 || k != 3) begin n_fail++; $display("FAIL periodic_spacing: got %0d,%0d,%0d (n=%0d) expected 10,13,16 (n=3)", exp_cyc[0], exp_cyc[1], exp_cyc[2], k); end
    n_tests++; if (done_cyc != 16 || off_at_done !== 1'b1) begin n_fail++; $display("FAIL periodic_stop: got done@%0d off=%b expected done@16 off=1", done_cyc, off_at_done); end
    tick();
    n_tests++; if ({busy, expiries} !== {1'b0, 8'd3}) begin n_fail++; $display("FAIL periodic_end: got busy=%b exp=%0d expected busy=0 exp=3", busy, expiries); end
  endtask

  task automatic test_watchdog();
    stuck = 1'b1;
    start_session(8'd3, 1'b0, 8'd0);
`ifdef TIMER_CTRL_WDOG_EN
    begin
      int err_cyc = -1, done_seen = 0;
      logic off_at_err = 1'b0;
      for (int c = 1; c <= 30 && err_cyc < 0; c++) begin
        tick();
        if (done === 1'b1) done_seen++;
        if (err === 1'b1) begin err_cyc = c; off_at_err = off; end
      end
      n_tests++; if (err_cyc != 9 || off_at_err !== 1'b1) begin n_fail++; $display("FAIL wdog_err: got err@%0d off=%b expected err@9 off=1", err_cyc, off_at_err); end
      n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL wdog_done: got %0d expected 0", done_seen); end
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wdog_idle: got %b expected 0", busy); end
    end
`else
    begin
      int bad = 0;
      for (int c = 1; c <= 40; c++) begin
        tick();
        if (err !== 1'b0 || busy !== 1'b1) bad++;
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wait_forever: got %0d bad cycles expected 0", bad); end
      abort = 1'b1; #1;
      n_tests++; if (off !== 1'b1) begin n_fail++; $display("FAIL wait_abort_off: got %b expected 1", off); end
      tick();
      abort = 1'b0;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_abort_idle: got %b expected 0", busy); end
    end
`endif
    stuck = 1'b0;
    tick();
  endtask

  // Periodic value=1: zeros at 8 and 10; abort exactly at cycle 10
  task automatic test_abort();
    start_session(8'd1, 1'b1, 8'd0);
    repeat (10) tick();
    n_tests++; if (tmr_out !== 8'h00 || expiries !== 8'd1) begin n_fail++; $display("FAIL abort_pre: got tmr=%h exp=%0d expected tmr=00 exp=1", tmr_out, expiries); end
    abort = 1'b1; #1;
    n_tests++; if ({off, on, ok, done, err} !== 5'b10000) begin n_fail++; $display("FAIL abort_cmds: got %b expected 10000", {off, on, ok, done, err}); end
    tick();
    abort = 1'b0;
    n_tests++; if ({busy, expiries} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL abort_end: got busy=%b exp=%0d expected busy=0 exp=1", busy, expiries); end
    tick();
  endtask

  task automatic test_saturate();
    int busy_bad = 0;
    start_session(8'd0, 1'b1, 8'd0);
    repeat (300) begin
      tick();
      if (busy !== 1'b1) busy_bad++;
    end
    n_tests++; if (busy_bad != 0) begin n_fail++; $display("FAIL sat_busy: got %0d low cycles expected 0", busy_bad); end
    n_tests++; if (expiries !== 8'hFF) begin n_fail++; $display("FAIL sat_count: got %h expected FF", expiries); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    start_session(8'd4, 1'b1, 8'd0);
    n_tests++; if (expiries !== 8'd0) begin n_fail++; $display("FAIL start_clear: got %0d expected 0", expiries); end
    repeat (5) tick();
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_load_ok: got %b expected 1", ok); end
    reset = 1'b1; #1;
    n_tests++; if (off !== 1'b0) begin n_fail++; $display("FAIL rst_no_off: got %b expected 0", off); end
    tick();
    reset = 1'b0;
    n_tests++; if ({busy, mode, value, expiries} !== 18'd0) begin n_fail++; $display("FAIL rst_mid_state: got %h expected 0", {busy, mode, value, expiries}); end
    start_session(8'd3, 1'b0, 8'd0);
    n_tests++; if (expiries !== 8'd0) begin n_fail++; $display("FAIL rst_new_exp: got %0d expected 0", expiries); end
    run_oneshot("after_rst");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_value = 8'd0; cfg_mode = 1'b0; cfg_periods = 8'd0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_watchdog();
    test_abort();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter WDOG_CYCLES, default 8: maximum cycles spent in WAIT_SET before a watchdog error.
REQ-002 clk  in  1  single clock; all logic is clocked on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request one timer session; sampled only in IDLE.
REQ-005 abort  in  1  terminate the session at once; highest priority outside IDLE.
REQ-006 cfg_value  in  8  initial count, captured on the start-accept cycle.
REQ-007 cfg_mode  in  1  0 = one-shot, 1 = periodic; captured on the start-accept cycle.
REQ-008 cfg_periods  in  8  periodic expiries before auto-stop (0 = unlimited); captured on the start-accept cycle.
REQ-009 tmr_out  in  8  timer status bus: 0xFF = off/powering, 0x00 = setting, otherwise the count.
REQ-010 on, off, ok  out  1 each  one-cycle command pulses to the timer.
REQ-011 mode  out  1 and value  out  8  load operands, driven with the captured config and valid while ok=1.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse on normal completion.
REQ-014 err  out  1  one-cycle pulse on watchdog timeout.
REQ-015 expiries  out  8  expiry count for the current session; saturates at 0xFF.

Function
REQ-016 FSM states SHALL be IDLE, PWR, WAIT_SET, LOAD, SKIP, RUN, STOP.
REQ-017 IDLE: when start=1, capture the config, clear expiries, and go to PWR.
REQ-018 PWR: assert on for exactly one cycle, then go to WAIT_SET.
REQ-019 WAIT_SET: when tmr_out==0x00, go to LOAD; otherwise stay and increment the watchdog counter.
REQ-020 LOAD: assert ok=1 with mode/value = captured config for one cycle, then go to SKIP.
REQ-021 SKIP: wait one cycle (timer in its second setting cycle), then go to RUN; the first RUN cycle sees tmr_out = cfg_value.
REQ-022 RUN, one-shot: the first cycle with tmr_out==0x00 SHALL increment expiries, pulse done, and go to IDLE without asserting off.
REQ-023 RUN, periodic: each cycle with tmr_out==0x00 SHALL increment expiries (saturating).
REQ-024 RUN, periodic: when cfg_periods≠0 and the incremented count equals cfg_periods, go to STOP.
REQ-025 STOP: assert off for one cycle, pulse done in that cycle, then go to IDLE.
REQ-026 abort=1 in any state other than IDLE SHALL assert off in that cycle and go to IDLE next cycle, with no done and no err.
REQ-027 abort takes priority over every other transition in the same cycle, including an expiry.
REQ-028 start while busy=1 SHALL be ignored; config SHALL NOT change mid-session.
REQ-029 on, off, and ok SHALL never be high in the same cycle.
REQ-030 expiries SHALL hold its value after a session ends until the next start is accepted.

Reset
REQ-031 reset SHALL set state=IDLE and clear on, off, ok, mode, value, busy, done, err, expiries, the captured config, and the watchdog counter, all to 0.
REQ-032 reset mid-session SHALL abandon the session without emitting off; the timer's own reset is the system's responsibility.

Configuration
REQ-033 With TIMER_CTRL_WDOG_EN defined: when the watchdog counter reaches WDOG_CYCLES in WAIT_SET, the block SHALL assert off and pulse err in that cycle, then go to IDLE.
REQ-034 Without TIMER_CTRL_WDOG_EN: there is no watchdog counter, WAIT_SET waits indefinitely, and err is tied to 0.

Structure
REQ-035 Package timer_ctrl_pkg SHALL hold the state encoding, TMR_OFF=8'hFF, TMR_SET=8'h00, and the default WDOG_CYCLES.
REQ-036 The saturating expiry counter SHALL be a sub-module, timer_ctrl_expcnt, with clear, increment, and 8-bit count.

Verification
REQ-037 Bench drives start with value=3, mode=0 against a timer model; it SHALL see on at T, ok in the cycle after the first tmr_out=0x00, done when the count hits 0, and expiries=1.
REQ-038 Bench drives periodic mode with value=2, periods=3; it SHALL see 3 expiries spaced 3 cycles apart, an off pulse together with done, and busy low after.
REQ-039 Bench holds tmr_out stuck at 0xFF with TIMER_CTRL_WDOG_EN; it SHALL see err plus off exactly 8 cycles after WAIT_SET entry, and no done.
REQ-040 Bench asserts abort during RUN in the same cycle as tmr_out=0x00; it SHALL see off, no done, no expiry increment, and IDLE next cycle.
REQ-041 Bench runs periodic mode with value=0, periods=0 for 300 cycles; expiries SHALL saturate at 0xFF and busy SHALL stay high.
REQ-042 Bench asserts reset during LOAD, then start on the next cycle; it SHALL see a clean new session with expiries=0.
